// File: rtl/crc_frame_tx.sv
// Byte FIFO feeding a send/busy sender; appends a CRC-8 (poly 0x07)
// byte after every FRAME_LEN payload bytes.
module crc_frame_tx #(
  parameter int FRAME_LEN = 8,
  parameter int DEPTH     = 16,
  parameter int ACK_WAIT  = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 i_data,
  input  logic                       i_valid,
  output logic [7:0]                 o_data,
  output logic                       o_send,
  input  logic                       i_busy,
  output logic                       o_is_crc,
  output logic [7:0]                 o_crc8,
  output logic [7:0]                 o_last_crc,
  output logic [7:0]                 o_frame_count,
  output logic [$clog2(DEPTH):0]     o_fifo_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] PAY_LEN = 8'(FRAME_LEN);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [15:0] ACK_W = 16'(ACK_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [7:0]    pay_q;
  logic [7:0]    crc_q;
  logic [15:0]   wait_q;
  logic [15:0]   wait_d;
  logic [7:0]    data_q;
  logic          is_crc_q;
  logic          send_q;
  logic [7:0]    last_q;
  logic [7:0]    frames_q;
  logic          ovf_q;

  logic frame_full;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic ack_to;
  logic done;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    return x;
  endfunction

  always_comb begin
    frame_full = (pay_q == PAY_LEN);
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_C);
    pop  = (state_q == IDLE) && !frame_full && !fifo_empty;
    // A full FIFO still accepts a byte when the head leaves this cycle
    push = i_valid && (!fifo_full || pop);
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
    wait_d = wait_q + 16'd1;
    ack_to = (state_q == WAIT_ACK) && !i_busy
             && (wait_d == ACK_W);
    done = is_crc_q && (ack_to ||
           ((state_q == WAIT_DONE) && !i_busy));
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem_q[wr_q] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      pay_q    <= '0;
      crc_q    <= '0;
      wait_q   <= '0;
      data_q   <= '0;
      is_crc_q <= 1'b0;
      send_q   <= 1'b0;
      last_q   <= '0;
      frames_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      send_q <= 1'b0;
      cnt_q  <= cnt_d;
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (i_valid && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (frame_full) begin
            data_q   <= crc_q;
            is_crc_q <= 1'b1;
            state_q  <= SEND;
          end else if (pop) begin
            data_q   <= mem_q[rd_q];
            is_crc_q <= 1'b0;
            crc_q    <= crc8_step(crc_q, mem_q[rd_q]);
            pay_q    <= pay_q + 8'd1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (!i_busy) begin
            send_q  <= 1'b1;
            wait_q  <= '0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (i_busy) begin
            state_q <= WAIT_DONE;
          end else begin
            wait_q <= wait_d;
            if (ack_to) begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!i_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (done) begin
        last_q   <= crc_q;
        crc_q    <= '0;
        pay_q    <= '0;
        frames_q <= frames_q + 8'd1;
      end
    end
  end

  assign o_data        = data_q;
  assign o_send        = send_q;
  assign o_is_crc      = is_crc_q;
  assign o_crc8        = crc_q;
  assign o_last_crc    = last_q;
  assign o_frame_count = frames_q;
  assign o_fifo_count  = cnt_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Scoreboard bench: a frame-level model predicts the sent byte stream,
// a monitor compares every o_send against it.
module tb_crc_frame_tx;

  localparam int FL  = 9;
  localparam int DP  = 16;
  localparam int AWT = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_busy = 1'b0;
  logic [7:0] o_data;
  logic       o_send;
  logic       o_is_crc;
  logic [7:0] o_crc8;
  logic [7:0] o_last_crc;
  logic [7:0] o_frame_count;
  logic [4:0] o_fifo_count;
  logic       o_overflow;

  crc_frame_tx #(
    .FRAME_LEN(FL),
    .DEPTH(DP),
    .ACK_WAIT(AWT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_data(o_data),
    .o_send(o_send),
    .i_busy(i_busy),
    .o_is_crc(o_is_crc),
    .o_crc8(o_crc8),
    .o_last_crc(o_last_crc),
    .o_frame_count(o_frame_count),
    .o_fifo_count(o_fifo_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];
  logic [7:0] frame [$];
  int m_frames = 0;
  logic [7:0] m_last = 8'h00;
  int mode = 0;
  int busy_len = 20;
  int sends = 0;

  // CRC as the remainder of msg(x)*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [7:0] msg [$]);
    logic [8:0] r;
    r = '0;
    foreach (msg[k]) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], msg[k][b]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    for (int b = 0; b < 8; b++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic accept(input logic [7:0] b);
    logic [7:0] c;
    exp_q.push_back({1'b0, b});
    frame.push_back(b);
    if (frame.size() == FL) begin
      c = crc_ref(frame);
      exp_q.push_back({1'b1, c});
      m_last = c;
      m_frames = (m_frames + 1) % 256;
      frame.delete();
    end
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    i_valid = 1'b1;
    i_data = b;
    if (acc) accept(b);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic check_status();
    chk("crc8", o_crc8, crc_ref(frame));
    chk("frame_count", o_frame_count, m_frames[7:0]);
    chk("last_crc", o_last_crc, m_last);
    chk("fifo_count_idle", o_fifo_count, 0);
  endtask

  // Monitor: every send must match the head of the expected stream
  initial begin : monitor
    logic [8:0] e;
    int ncyc;
    int last_send;
    ncyc = 0;
    last_send = -100;
    forever begin
      @(negedge clk);
      ncyc++;
      if (o_send === 1'b1) begin
        sends++;
        checks++;
        if (ncyc - last_send < 3) begin
          errors++;
          $display("FAIL send_spacing actual=%0d required>=3",
                   ncyc - last_send);
        end
        last_send = ncyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send actual=%0h required=none",
                   {o_is_crc, o_data});
        end else begin
          e = exp_q.pop_front();
          chk("send_byte", {o_is_crc, o_data}, e);
        end
      end
    end
  end

  // Sink: 0 never busy, 1 busy after each send, 2 always busy, 3 manual
  initial begin : sink
    forever begin
      @(negedge clk);
      if (mode == 0) begin
        i_busy = 1'b0;
      end else if (mode == 2) begin
        i_busy = 1'b1;
      end else if (mode == 1) begin
        if (o_send === 1'b1) begin
          @(negedge clk);
          i_busy = 1'b1;
          repeat (busy_len) @(negedge clk);
          i_busy = 1'b0;
        end else begin
          i_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] msg [9];
    int n;
    int base;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
            8'h36, 8'h37, 8'h38, 8'h39};

    // Reset with input strobes present
    reset_n = 1'b0;
    mode = 0;
    i_valid = 1'b1;
    i_data = 8'hAA;
    @(negedge clk);
    chk("reset_outputs0", {o_data, o_send, o_is_crc, o_crc8,
        o_last_crc, o_frame_count, o_fifo_count, o_overflow}, 0);
    i_data = 8'h55;
    @(negedge clk);
    chk("reset_outputs1", {o_data, o_send, o_is_crc, o_crc8,
        o_last_crc, o_frame_count, o_fifo_count, o_overflow}, 0);
    i_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Latency of the first byte with an idle sink
    i_valid = 1'b1;
    i_data = msg[0];
    accept(msg[0]);
    @(negedge clk);
    i_valid = 1'b0;
    chk("lat_no_send_t", o_send, 0);
    @(negedge clk);
    chk("lat_data_t1", {o_is_crc, o_data}, {1'b0, msg[0]});
    chk("lat_no_send_t1", o_send, 0);
    @(negedge clk);
    chk("lat_send_t2", o_send, 1);

    // Check value over "123456789"
    mode = 1;
    busy_len = 20;
    for (int i = 1; i < 9; i++) push(msg[i], 1'b1);
    drain();
    chk("check_value", o_last_crc, 8'hF4);
    chk("check_frames", o_frame_count, 1);
    chk("check_crc_cleared", o_crc8, 0);

    // Random bursts with random sink behaviour
    for (int k = 0; k < 6; k++) begin
      mode = int'($urandom_range(0, 1));
      busy_len = int'($urandom_range(1, 20));
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        push(8'($urandom), 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      check_status();
    end

    // Align to a frame boundary
    mode = 1;
    while (frame.size() != 0) push(8'($urandom), 1'b1);
    drain();
    check_status();

    // Fill to full with the sender stalled
    i_busy = 1'b1;
    mode = 2;
    for (int i = 0; i <= DP; i++) push(8'($urandom), 1'b1);
    chk("full_count", o_fifo_count, DP);
    chk("full_no_ovf", o_overflow, 0);

    // Release for one byte, then push exactly on the pop edge
    mode = 3;
    i_busy = 1'b0;
    n = 0;
    while (o_send !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("release_send_seen", o_send, 1);
    i_busy = 1'b1;
    @(negedge clk);
    i_busy = 1'b0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data = 8'($urandom);
    accept(i_data);
    @(negedge clk);
    i_valid = 1'b0;
    i_busy = 1'b1;
    chk("pushpop_count", o_fifo_count, DP);
    chk("pushpop_no_ovf", o_overflow, 0);

    // Pushes while full and stalled are dropped
    push(8'hDE, 1'b0);
    push(8'hAD, 1'b0);
    chk("ovf_count", o_fifo_count, DP);
    chk("ovf_flag", o_overflow, 1);
    mode = 1;
    busy_len = 2;
    drain();
    check_status();
    chk("ovf_sticky", o_overflow, 1);

    // Reset while the sender is busy on the third byte of a frame
    busy_len = 20;
    while (frame.size() != 0) push(8'($urandom), 1'b1);
    drain();
    base = sends;
    for (int i = 0; i < 3; i++) push(8'($urandom), 1'b1);
    n = 0;
    while (sends < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_sends", sends - base, 3);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    frame.delete();
    m_frames = 0;
    m_last = 8'h00;
    @(negedge clk);
    chk("mid_reset_send0", o_send, 0);
    @(negedge clk);
    chk("mid_reset_outputs", {o_data, o_send, o_is_crc, o_crc8,
        o_last_crc, o_frame_count, o_fifo_count, o_overflow}, 0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    for (int i = 0; i < FL; i++) push(8'($urandom), 1'b1);
    drain();
    check_status();
    chk("mid_frames_after", o_frame_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_tx.md
Name: crc_frame_tx

Overview:
- Sits between the UART receive path (single-pulsed byte strobe) and a byte-oriented sender with a send/busy handshake, such as the inter-FPGA sender or the UART transmitter.
- Buffers incoming bytes in a FIFO and forwards them to the sender one at a time.
- After every FRAME_LEN payload bytes it inserts one CRC-8 byte computed over those payload bytes.
- Exposes the running CRC, the last frame's CRC and a frame counter for the 7-segment display.

Parameters:
- FRAME_LEN, 8: payload bytes per frame; legal range 1..255.
- DEPTH, 16: FIFO depth in bytes; must be a power of two, at least 2.
- ACK_WAIT, 15: cycles to wait for i_busy to rise after o_send before treating the byte as already sent.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_data  in  8  input byte; sampled when i_valid=1.
- i_valid  in  1  one-cycle byte strobe, e.g. a single-pulsed UART ready.
- o_data  out  8  byte presented to the sender.
- o_send  out  1  one-cycle send request.
- i_busy  in  1  sender busy flag.
- o_is_crc  out  1  high while o_data is the inserted CRC byte.
- o_crc8  out  8  running CRC of the current frame's bytes sent so far.
- o_last_crc  out  8  CRC byte of the most recently completed frame.
- o_frame_count  out  8  count of completed frames; wraps at 256.
- o_fifo_count  out  log2(DEPTH)+1  FIFO occupancy.
- o_overflow  out  1  sticky flag: an input byte was dropped.

Behaviour:
- Reset (reset_n=0 at a clk edge): every output is 0, the FIFO is empty, payload count is 0, CRC is 0x00, state is IDLE.
  - Reset overrides all other activity, including mid-transfer. o_send is never asserted in the reset cycle.
- CRC-8 definition: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Updated with each payload byte at the moment it is popped into o_data.
- FIFO write: i_valid=1 pushes i_data.
  - When full, the push is dropped and o_overflow is set, unless a pop occurs in the same cycle; then the push is accepted.
  - Push and pop in the same cycle leave o_fifo_count unchanged.
- FIFO pointers wrap modulo DEPTH. o_fifo_count ranges 0..DEPTH.
- State machine: IDLE, SEND, WAIT_ACK, WAIT_DONE.
  - IDLE, payload count = FRAME_LEN: o_data <= CRC, o_is_crc <= 1, go to SEND. The CRC byte takes priority over FIFO data.
  - IDLE, FIFO not empty: pop the head into o_data, o_is_crc <= 0, CRC <= crc8(CRC, byte), payload count +1, go to SEND.
  - IDLE, otherwise: stay.
  - SEND: when i_busy=0, drive o_send=1 for exactly this cycle, clear the wait counter, go to WAIT_ACK. While i_busy=1, hold in SEND with o_send=0.
  - WAIT_ACK: i_busy=1 goes to WAIT_DONE. Otherwise the counter increments; when it reaches ACK_WAIT, go to IDLE.
  - WAIT_DONE: i_busy=0 goes to IDLE.
- Leaving WAIT_ACK or WAIT_DONE toward IDLE when o_is_crc=1 completes the frame:
  - o_last_crc <= CRC;
  - CRC <= 0x00;
  - payload count <= 0;
  - o_frame_count +1, wrapping 255 to 0.
- o_data and o_is_crc are held stable from the pop/select cycle until the next pop/select.
- Latency: i_valid sampled at edge t with the FIFO empty and the machine IDLE gives o_data valid after edge t+1 and o_send=1 in the cycle after edge t+2 (provided i_busy=0).
- Minimum spacing between o_send pulses is 3 cycles.
- o_overflow clears only on reset.

Test Plan:
- Reset state: reset_n=0 for 2 cycles with i_valid pulses applied -> all outputs 0, o_fifo_count=0, no o_send.
- Latency with a fast sink: FRAME_LEN=1, i_busy tied 0, push 0x01 -> o_send at t+2 with o_data=0x01, then o_send with o_data=0x07 and o_is_crc=1 after ACK_WAIT+1 cycles; o_last_crc=0x07, o_frame_count=1.
- Standard check value: FRAME_LEN=9, sink model raising busy 1 cycle after o_send for 20 cycles, push ASCII "123456789" back-to-back -> nine payload bytes in order, then CRC byte 0xF4; o_frame_count=1, o_crc8=0x00 afterwards.
- Overflow: DEPTH=4, i_busy held 1, push 6 bytes -> o_fifo_count=4 after one pop has occurred (the first byte is held in SEND), o_overflow=1; release busy -> only accepted bytes are sent.
- Simultaneous push and pop at full: FIFO full and IDLE popping while i_valid=1 -> byte accepted, count stays DEPTH, o_overflow stays 0.
- Mid-transfer reset: reset_n=0 while in WAIT_DONE after 3 of 8 bytes -> next frame restarts with CRC 0x00 and payload count 0, o_frame_count=0.
